// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator for a 4:1 channel mux: grants one requester per burst
// of burst_len beats and only moves sel at burst boundaries.
module mux_sel_rr_arbiter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] burst_len,
    input  logic               out_ready,
    output logic [1:0]         sel,
    output logic [3:0]         grant,
    output logic               sel_valid,
    output logic               sel_last
);

    typedef enum logic { IDLE = 1'b0, GRANT = 1'b1 } state_t;

    state_t             state;
    logic [1:0]         cur;
    logic [1:0]         ptr;
    logic [DWELL_W-1:0] rem;

    logic               found;
    logic [1:0]         winner;
    logic [1:0]         idx;
    logic               beat;
    logic               abort;
    logic               burst_end;
    logic [DWELL_W-1:0] load_len;
    logic [3:0]         onehot;

    // ptr always equals cur while granted, so one search base covers idle and re-arbitration
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        beat      = (state == GRANT) && out_ready && req[cur];
        abort     = (state == GRANT) && !req[cur];
        burst_end = abort || (beat && (rem == DWELL_W'(1)));
        load_len  = (burst_len == '0) ? DWELL_W'(1) : burst_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur   <= 2'd0;
            ptr   <= 2'd3;
            rem   <= '0;
        end else if (state == IDLE || burst_end) begin
            if (found) begin
                state <= GRANT;
                cur   <= winner;
                ptr   <= winner;
                rem   <= load_len;
            end else begin
                state <= IDLE;
            end
        end else if (beat) begin
            rem <= rem - DWELL_W'(1);
        end
    end

    always_comb begin
        onehot    = 4'b0001 << cur;
        sel       = cur;
        sel_valid = (state == GRANT);
        grant     = sel_valid ? onehot : 4'b0000;
        sel_last  = sel_valid && (rem == DWELL_W'(1));
    end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed vector table plus randomized run against a behavioural arbiter model.
module tb_mux_sel_rr_arbiter;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] burst_len;
    logic          out_ready;
    logic [1:0]    sel;
    logic [3:0]    grant;
    logic          sel_valid;
    logic          sel_last;

    mux_sel_rr_arbiter #(.DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .burst_len(burst_len), .out_ready(out_ready),
        .sel(sel), .grant(grant), .sel_valid(sel_valid), .sel_last(sel_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic [DW-1:0] bl;
        logic          rdy;
        logic [1:0]    e_sel;
        logic [3:0]    e_grant;
        logic          e_valid;
        logic          e_last;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_cur, m_ptr, m_rem;
    bit m_act;

    function automatic int arb(int base, logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    function automatic void model_edge(logic r_rst, logic [3:0] r_req, int bl, logic rdy);
        bit rearb;
        int w;
        if (r_rst) begin
            m_cur = 0; m_ptr = 3; m_rem = 0; m_act = 0;
            return;
        end
        rearb = !m_act;
        if (m_act) begin
            if (!r_req[m_cur]) rearb = 1;
            else if (rdy) begin
                if (m_rem == 1) rearb = 1;
                else m_rem = m_rem - 1;
            end
        end
        if (rearb) begin
            w = arb(m_act ? m_cur : m_ptr, r_req);
            if (w >= 0) begin
                m_cur = w; m_ptr = w; m_rem = (bl == 0) ? 1 : bl; m_act = 1;
            end else m_act = 0;
        end
    endfunction

    function automatic void add(logic r, logic [3:0] q, int bl, logic rd,
                                int es, logic [3:0] eg, logic ev, logic el);
        vec_t v;
        v.rst = r; v.req = q; v.bl = DW'(bl); v.rdy = rd;
        v.e_sel = 2'(es); v.e_grant = eg; v.e_valid = ev; v.e_last = el;
        tbl.push_back(v);
    endfunction

    task automatic step(logic r, logic [3:0] q, logic [DW-1:0] bl, logic rd);
        rst = r; req = q; burst_len = bl; out_ready = rd;
        @(posedge clk);
        model_edge(r, q, int'(bl), rd);
        #1;
    endtask

    task automatic cmp(string name, logic [1:0] es, logic [3:0] eg, logic ev, logic el);
        checks++;
        if (sel !== es || grant !== eg || sel_valid !== ev || sel_last !== el) begin
            errors++;
            $display("FAIL %s: got sel=%0d grant=%b valid=%b last=%b, want sel=%0d grant=%b valid=%b last=%b",
                     name, sel, grant, sel_valid, sel_last, es, eg, ev, el);
        end
    endtask

    initial begin
        // reset, held with all requests up
        add(1, 4'hF, 2, 1, 0, 4'b0000, 0, 0);
        add(1, 4'hF, 2, 1, 0, 4'b0000, 0, 0);
        // fairness, 2-beat bursts: 0,0,1,1,2,2,3,3,0,0
        add(0, 4'hF, 2, 1, 0, 4'b0001, 1, 0);
        add(0, 4'hF, 2, 1, 0, 4'b0001, 1, 1);
        add(0, 4'hF, 2, 1, 1, 4'b0010, 1, 0);
        add(0, 4'hF, 2, 1, 1, 4'b0010, 1, 1);
        add(0, 4'hF, 2, 1, 2, 4'b0100, 1, 0);
        add(0, 4'hF, 2, 1, 2, 4'b0100, 1, 1);
        add(0, 4'hF, 2, 1, 3, 4'b1000, 1, 0);
        add(0, 4'hF, 2, 1, 3, 4'b1000, 1, 1);
        add(0, 4'hF, 2, 1, 0, 4'b0001, 1, 0);
        add(0, 4'hF, 2, 1, 0, 4'b0001, 1, 1);
        // single requester ch2, 3 beats, regrant without bubble
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 0);
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 0);
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 1);
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 0);
        // backpressure at rem=2, then exactly two beats
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0100, 3, 0, 2, 4'b0100, 1, 0);
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 1);
        add(0, 4'b0100, 3, 1, 2, 4'b0100, 1, 0);
        // burst_len 0 -> 1-beat bursts once the current burst drains
        add(0, 4'b0100, 0, 1, 2, 4'b0100, 1, 0);
        add(0, 4'b0100, 0, 1, 2, 4'b0100, 1, 1);
        add(0, 4'b0100, 0, 1, 2, 4'b0100, 1, 1);
        add(0, 4'b0100, 0, 1, 2, 4'b0100, 1, 1);
        // abort under backpressure: ch1 drops -> ch2, then ch2 drops -> idle
        add(0, 4'b0010, 5, 1, 1, 4'b0010, 1, 0);
        add(0, 4'b0110, 5, 1, 1, 4'b0010, 1, 0);
        add(0, 4'b0100, 5, 0, 2, 4'b0100, 1, 0);
        add(0, 4'b0000, 5, 0, 2, 4'b0000, 0, 0);
        // reset mid-burst on ch3 with rem=4
        add(0, 4'b1000, 4, 0, 3, 4'b1000, 1, 0);
        add(0, 4'b1000, 4, 0, 3, 4'b1000, 1, 0);
        add(1, 4'b1000, 4, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b1000, 4, 1, 3, 4'b1000, 1, 0);
        add(0, 4'b1000, 4, 1, 3, 4'b1000, 1, 0);
        add(0, 4'b1000, 4, 1, 3, 4'b1000, 1, 0);
        add(0, 4'b1000, 4, 1, 3, 4'b1000, 1, 1);

        m_cur = 0; m_ptr = 3; m_rem = 0; m_act = 0;
        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].bl, tbl[i].rdy);
            cmp($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_grant, tbl[i].e_valid, tbl[i].e_last);
        end

        // randomized run; requests toggle sparsely so bursts run to completion often
        begin
            logic [3:0] q = 4'hF;
            logic [3:0] e_g;
            for (int c = 0; c < 3000; c++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 7) == 0) q[b] = ~q[b];
                step(($urandom_range(0, 99) == 0), q, DW'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) != 0));
                e_g = m_act ? (4'b0001 << m_cur) : 4'b0000;
                cmp($sformatf("rand%0d", c), 2'(m_cur), e_g, m_act, m_act && (m_rem == 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
